tea_encrypt_core: RTL



---
 rtl/tea_pkg.sv | 40 ++++
 rtl/tea_enc_round.sv | 21 ++
 rtl/tea_encrypt_core.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tea_pkg.sv
// Shared TEA definitions: schedule constants, controller states, key-word
// selectors and the Feistel mixing function used by the encrypt round.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;
    localparam logic [31:0] TEA_SUM32 = 32'hC6EF3720;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } tea_state_e;

    // Key layout matches the decrypt block: k0 is the most significant word.
    function automatic logic [31:0] k0(input logic [127:0] key_w);
        return key_w[127:96];
    endfunction

    function automatic logic [31:0] k1(input logic [127:0] key_w);
        return key_w[95:64];
    endfunction

    function automatic logic [31:0] k2(input logic [127:0] key_w);
        return key_w[63:32];
    endfunction

    function automatic logic [31:0] k3(input logic [127:0] key_w);
        return key_w[31:0];
    endfunction

    function automatic logic [31:0] tea_f(
        input logic [31:0] v,
        input logic [31:0] ka,
        input logic [31:0] kb,
        input logic [31:0] s
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

endpackage

// File: rtl/tea_enc_round.sv
// One combinational TEA encrypt cycle: advances sum, then updates v0 and v1
// in turn, with v1 mixing the freshly updated v0.
module tea_enc_round
    import tea_pkg::*;
#(
    parameter logic [31:0] DELTA = TEA_DELTA
) (
    input  logic [31:0]  v0_i,
    input  logic [31:0]  v1_i,
    input  logic [31:0]  sum_i,
    input  logic [127:0] key_i,
    output logic [31:0]  v0_o,
    output logic [31:0]  v1_o,
    output logic [31:0]  sum_o
);

    assign sum_o = sum_i + DELTA;
    assign v0_o  = v0_i + tea_f(v1_i, k0(key_i), k1(key_i), sum_o);
    assign v1_o  = v1_i + tea_f(v0_o, k2(key_i), k3(key_i), sum_o);

endmodule

// File: rtl/tea_encrypt_core.sv
// Iterative TEA encryptor: one Feistel cycle per clock, ROUNDS cycles per
// block, valid/ready on both sides, final sum exported as the decrypt seed.
module tea_encrypt_core
    import tea_pkg::*;
#(
    parameter int          ROUNDS = 32,
    parameter logic [31:0] DELTA  = TEA_DELTA
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic [31:0]  out_sum
);

    if (ROUNDS < 1 || ROUNDS > 255) begin : g_rounds_range
        $error("tea_encrypt_core: ROUNDS=%0d outside legal range 1..255", ROUNDS);
    end

    localparam logic [7:0] LAST_CNT = 8'(ROUNDS - 1);

    tea_state_e   state_q, state_d;
    logic [31:0]  v0_q, v0_d;
    logic [31:0]  v1_q, v1_d;
    logic [31:0]  sum_q, sum_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [63:0]  out_data_q, out_data_d;
    logic [31:0]  out_sum_q, out_sum_d;

    logic [31:0]  rnd_v0, rnd_v1, rnd_sum;

    tea_enc_round #(
        .DELTA (DELTA)
    ) u_round (
        .v0_i  (v0_q),
        .v1_i  (v1_q),
        .sum_i (sum_q),
        .key_i (key_q),
        .v0_o  (rnd_v0),
        .v1_o  (rnd_v1),
        .sum_o (rnd_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            v0_q       <= '0;
            v1_q       <= '0;
            sum_q      <= '0;
            key_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_sum_q  <= '0;
        end else begin
            state_q    <= state_d;
            v0_q       <= v0_d;
            v1_q       <= v1_d;
            sum_q      <= sum_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            out_sum_q  <= out_sum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        v0_d       = v0_q;
        v1_d       = v1_q;
        sum_d      = sum_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sum_d  = out_sum_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    v0_d    = in_data[63:32];
                    v1_d    = in_data[31:0];
                    key_d   = key;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                v0_d  = rnd_v0;
                v1_d  = rnd_v1;
                sum_d = rnd_sum;
                cnt_d = cnt_q + 8'd1;
                // The output registers are only written on the last round so
                // they keep the previously delivered block while busy.
                if (cnt_q == LAST_CNT) begin
                    out_data_d = {rnd_v0, rnd_v1};
                    out_sum_d  = rnd_sum;
                    state_d    = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_data = out_data_q;
    assign out_sum  = out_sum_q;

endmodule
